// File: rtl/nco_cordic_phase_det.sv
// Vectoring-mode CORDIC phase detector: converts a signed (cos, sin) pair into an
// unsigned phase (fraction of a turn, NCO accumulator convention) and a gained magnitude.
module nco_cordic_phase_det #(
  parameter int unsigned mpr   = 12,
  parameter int unsigned apr   = 22,
  parameter int unsigned niter = 16,
  parameter int unsigned gbits = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [mpr-1:0]   sin_i,
  input  logic [mpr-1:0]   cos_i,
  output logic [apr-1:0]   phase_o,
  output logic [mpr+1:0]   mag_o,
  output logic             out_valid
);

  localparam int unsigned W  = mpr + 2 + gbits;
  localparam int unsigned ZW = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned MW = mpr + 2;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic signed [W-1:0]   r_x, w_x_nxt;
  logic signed [W-1:0]   r_y, w_y_nxt;
  logic [ZW-1:0]         r_z, w_z_nxt;
  logic                  r_zero, w_zero_nxt;
  logic [apr-1:0]        r_phase, w_phase_nxt;
  logic [MW-1:0]         r_mag, w_mag_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_ready;

  logic signed [W-1:0]   w_sin_ext;
  logic signed [W-1:0]   w_cos_ext;
  logic signed [W-1:0]   w_xs;
  logic signed [W-1:0]   w_ys;
  logic [ZW-1:0]         w_atan;

  // atan(2^-i) on a 2^32 full-turn scale, rounded
  function automatic logic [ZW-1:0] atan_rom(input logic [CW-1:0] idx);
    logic [ZW-1:0] v;
    case (idx)
      5'd0:    v = 32'd536870912;
      5'd1:    v = 32'd316933406;
      5'd2:    v = 32'd167458907;
      5'd3:    v = 32'd85004756;
      5'd4:    v = 32'd42667331;
      5'd5:    v = 32'd21354465;
      5'd6:    v = 32'd10679838;
      5'd7:    v = 32'd5340245;
      5'd8:    v = 32'd2670163;
      5'd9:    v = 32'd1335087;
      5'd10:   v = 32'd667544;
      5'd11:   v = 32'd333772;
      5'd12:   v = 32'd166886;
      5'd13:   v = 32'd83443;
      5'd14:   v = 32'd41722;
      5'd15:   v = 32'd20861;
      5'd16:   v = 32'd10430;
      5'd17:   v = 32'd5215;
      5'd18:   v = 32'd2608;
      5'd19:   v = 32'd1304;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Two headroom bits above the sample, guard bits below
  assign w_sin_ext = {{2{sin_i[mpr-1]}}, sin_i, {gbits{1'b0}}};
  assign w_cos_ext = {{2{cos_i[mpr-1]}}, cos_i, {gbits{1'b0}}};
  assign w_xs      = r_x >>> r_cnt;
  assign w_ys      = r_y >>> r_cnt;
  assign w_atan    = atan_rom(r_cnt);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_z_nxt     = r_z;
    w_zero_nxt  = r_zero;
    w_phase_nxt = r_phase;
    w_mag_nxt   = r_mag;
    w_valid_nxt = r_valid;
    if (clken) begin
      w_valid_nxt = 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid && r_ready) begin
            // Fold the left half-plane onto the right so the rotation converges
            if (cos_i[mpr-1]) begin
              w_x_nxt = -w_cos_ext;
              w_y_nxt = -w_sin_ext;
              w_z_nxt = 32'h8000_0000;
            end else begin
              w_x_nxt = w_cos_ext;
              w_y_nxt = w_sin_ext;
              w_z_nxt = '0;
            end
            w_zero_nxt  = (sin_i == '0) && (cos_i == '0);
            w_cnt_nxt   = '0;
            w_state_nxt = ITER;
          end
        end
        ITER: begin
          if (!r_y[W-1]) begin
            w_x_nxt = r_x + w_ys;
            w_y_nxt = r_y - w_xs;
            w_z_nxt = r_z + w_atan;
          end else begin
            w_x_nxt = r_x - w_ys;
            w_y_nxt = r_y + w_xs;
            w_z_nxt = r_z - w_atan;
          end
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(niter - 1)) begin
            w_phase_nxt = r_zero ? '0 : w_z_nxt[ZW-1 -: apr];
            w_mag_nxt   = r_zero ? '0 : w_x_nxt[W-1:gbits];
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_zero  <= 1'b0;
      r_phase <= '0;
      r_mag   <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_z     <= w_z_nxt;
      r_zero  <= w_zero_nxt;
      r_phase <= w_phase_nxt;
      r_mag   <= w_mag_nxt;
      r_valid <= w_valid_nxt;
      r_ready <= (w_state_nxt == IDLE);
    end
  end

  assign in_ready  = r_ready;
  assign phase_o   = r_phase;
  assign mag_o     = r_mag;
  assign out_valid = r_valid;

endmodule
